// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch memory: FSM state codes,
// error-bit positions and the byte-lane mapping used when packing words.
package fetch_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Positions of the flags inside rsp_err
    localparam int unsigned ERR_MISALIGN = 0;
    localparam int unsigned ERR_RANGE    = 1;
    localparam int unsigned ERR_W        = 2;

    // Byte lane (0 = least significant) that receives the byte read from addr+i.
    function automatic int unsigned byte_lane(
        input int unsigned i,
        input int unsigned word_bytes,
        input bit          big_endian
    );
        return big_endian ? (word_bytes - 1 - i) : i;
    endfunction

endpackage

// File: rtl/imem_byte_array.sv
// Byte-wide instruction storage: one synchronous write port for preloading and
// a combinational read of WORD_BYTES consecutive bytes. Bytes past the top of
// the array read as zero instead of wrapping to address 0.
module imem_byte_array #(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned WORD_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [7:0]                 wr_data,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [WORD_BYTES-1:0][7:0] rd_bytes
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned AW1   = ADDR_W + 1;

    // Contents are deliberately not reset; the program is loaded in-circuit.
    logic [7:0] mem [DEPTH];

    // Preload write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Multi-byte read; the extra address bit flags bytes beyond the top
    for (genvar i = 0; i < WORD_BYTES; i++) begin : g_rd
        logic [ADDR_W:0] byte_addr;

        always_comb begin
            byte_addr   = {1'b0, rd_addr} + AW1'(i);
            rd_bytes[i] = byte_addr[ADDR_W] ? 8'h00 : mem[byte_addr[ADDR_W-1:0]];
        end
    end

endmodule

// File: rtl/instr_mem_fetch.sv
// Instruction memory with a valid/ready fetch port. A request is accepted in
// IDLE, the word is captured RD_LATENCY-1 edges later and then held in RESP
// until the consumer takes it. Alignment and range flags travel with the data.
module instr_mem_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned WORD_BYTES = 4,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BIG_ENDIAN = 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    ld_en,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [7:0]              ld_data,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [8*WORD_BYTES-1:0] rsp_data,
    output logic [ERR_W-1:0]        rsp_err,
    output logic                    busy
);

    localparam int unsigned DATA_W = 8 * WORD_BYTES;
    localparam int unsigned CNT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int unsigned OFF_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned AW1    = ADDR_W + 1;

    logic [1:0]                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [DATA_W-1:0]          data_q;
    logic [ERR_W-1:0]           err_q;
    logic                       accept;
    logic                       capture;
    logic [ADDR_W-1:0]          rd_addr;
    logic [WORD_BYTES-1:0][7:0] rd_bytes;
    logic [DATA_W-1:0]          word_packed;
    logic [ERR_W-1:0]           word_err;
    logic [ADDR_W:0]            last_addr;

    assign accept = req_valid && req_ready;

    // With single-cycle latency the capture edge is the accept edge, so the
    // array must be addressed by req_addr before addr_q has been loaded.
    assign rd_addr = (state_q == ST_IDLE) ? req_addr : addr_q;

    imem_byte_array #(
        .ADDR_W     (ADDR_W),
        .WORD_BYTES (WORD_BYTES)
    ) u_array (
        .clk      (clk),
        .wr_en    (ld_en),
        .wr_addr  (ld_addr),
        .wr_data  (ld_data),
        .rd_addr  (rd_addr),
        .rd_bytes (rd_bytes)
    );

    // Place each fetched byte in its lane according to the configured byte order
    always_comb begin
        word_packed = '0;
        for (int unsigned i = 0; i < WORD_BYTES; i++) begin
            word_packed[8*byte_lane(i, WORD_BYTES, BIG_ENDIAN != 0) +: 8] = rd_bytes[i];
        end
    end

    // Alignment and range flags for the address currently being read
    always_comb begin
        last_addr              = {1'b0, rd_addr} + AW1'(WORD_BYTES - 1);
        word_err               = '0;
        word_err[ERR_MISALIGN] = (WORD_BYTES > 1) && (rd_addr[OFF_W-1:0] != '0);
        word_err[ERR_RANGE]    = last_addr[ADDR_W];
    end

    // State register, latency counter and latched request address
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic: accept, count down the latency, retire the response
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        capture = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d = req_addr;
                    if (RD_LATENCY == 1) begin
                        capture = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = CNT_W'(RD_LATENCY - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Response registers; the memory read here sees contents before any
    // preload write on the same edge
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data_q <= '0;
            err_q  <= '0;
        end else if (capture) begin
            data_q <= word_packed;
            err_q  <= word_err;
        end
    end

    // Handshake and status outputs
    always_comb begin
        req_ready = (state_q == ST_IDLE) && !ld_en && clr;
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
    end

    assign rsp_data = data_q;
    assign rsp_err  = err_q;

endmodule
